// File: rtl/mm_cios_stream.sv
// Word-serial CIOS Montgomery multiplier: R = X*Y*2^(-K*N) mod M, one KxK multiply per cycle.
// Operands stream in LS word first; result streams out with ready/valid backpressure.
module mm_cios_stream #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mm_start,
  input  logic         sq_mode,
  input  logic [K-1:0] m_prime,
  input  logic         in_valid,
  input  logic [K-1:0] mm_x,
  input  logic [K-1:0] mm_y,
  input  logic [K-1:0] mm_m,
  output logic [K-1:0] mm_result,
  output logic         mm_valid,
  input  logic         mm_ready,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, REDQ, RED, SUB, OUT} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   JSEL = (ADDR_W + 1)'(N);

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q, i_q, oidx_q;
  logic [ADDR_W:0]     j_q;
  logic                busy_q, valid_q;
  logic [K-1:0]        result_q;

  logic [K-1:0]        x_q [N];
  logic [K-1:0]        y_q [N];
  logic [K-1:0]        m_q [N];
  logic [K-1:0]        t_q [N];
  logic [K-1:0]        d_q [N];
  logic [K-1:0]        tn_q, tn1_q, c_q, q_q, mprime_q;
  logic                sq_q, borrow_q, use_d_q;

  logic [ADDR_W-1:0]   jx, nidx;
  logic                last_j;
  logic [K-1:0]        mul_a, mul_b, sel_word;
  logic [2*K-1:0]      prod_d, mac_d;
  logic [K:0]          fold_d, diff_d;

  function automatic logic [K-1:0] pick_word(input logic ud, input logic [K-1:0] dw,
                                             input logic [K-1:0] tw);
    return ud ? dw : tw;
  endfunction

  assign jx     = j_q[ADDR_W-1:0];
  assign last_j = (jx == LAST);
  assign nidx   = valid_q ? oidx_q + ADDR_W'(1) : '0;

  // Single shared multiplier: x*y in MUL, t0*m' in REDQ, q*m in RED
  always_comb begin
    mul_a = x_q[jx];
    mul_b = y_q[i_q];
    if (state_q == REDQ) begin
      mul_a = t_q[0];
      mul_b = mprime_q;
    end else if (state_q == RED) begin
      mul_a = q_q;
      mul_b = m_q[jx];
    end
  end

  assign prod_d   = {{K{1'b0}}, mul_a} * {{K{1'b0}}, mul_b};
  assign mac_d    = prod_d + {{K{1'b0}}, t_q[jx]} + {{K{1'b0}}, c_q};
  assign fold_d   = {1'b0, tn_q} + {1'b0, mac_d[2*K-1:K]};
  assign diff_d   = {1'b0, t_q[jx]} - {1'b0, m_q[jx]} - {{K{1'b0}}, borrow_q};
  assign sel_word = pick_word(use_d_q, d_q[nidx], t_q[nidx]);

  // Datapath storage; cleared by the start handshake rather than by reset
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (mm_start) begin
          sq_q     <= sq_mode;
          mprime_q <= m_prime;
          tn_q     <= '0;
          tn1_q    <= '0;
          for (int k = 0; k < N; k++) t_q[k] <= '0;
        end
      end
      LOAD: begin
        c_q <= '0;
        if (in_valid) begin
          x_q[cnt_q] <= mm_x;
          y_q[cnt_q] <= sq_q ? mm_x : mm_y;
          m_q[cnt_q] <= mm_m;
        end
      end
      MUL: begin
        t_q[jx] <= mac_d[K-1:0];
        c_q     <= mac_d[2*K-1:K];
        if (last_j) begin
          tn_q  <= fold_d[K-1:0];
          tn1_q <= {{(K-1){1'b0}}, fold_d[K]};
        end
      end
      REDQ: begin
        q_q      <= prod_d[K-1:0];
        c_q      <= '0;
        borrow_q <= 1'b0;
      end
      RED: begin
        c_q <= mac_d[2*K-1:K];
        if (jx != '0) t_q[jx - ADDR_W'(1)] <= mac_d[K-1:0];
        if (last_j) begin
          t_q[LAST] <= fold_d[K-1:0];
          tn_q      <= tn1_q + {{(K-1){1'b0}}, fold_d[K]};
          tn1_q     <= '0;
          c_q       <= '0;
        end
      end
      SUB: begin
        if (j_q != JSEL) begin
          d_q[jx]  <= diff_d[K-1:0];
          borrow_q <= diff_d[K];
        end else begin
          use_d_q  <= (tn_q != '0) || !borrow_q;
        end
      end
      default: ;
    endcase
  end

  // Control FSM; rst_n is active-high
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      oidx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (mm_start) begin
          state_q <= LOAD;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          i_q     <= '0;
          j_q     <= '0;
        end
        LOAD: if (in_valid) begin
          if (cnt_q == LAST) begin
            state_q <= MUL;
            j_q     <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        MUL: if (last_j) begin
          j_q     <= '0;
          state_q <= REDQ;
        end else begin
          j_q <= j_q + (ADDR_W + 1)'(1);
        end
        REDQ: state_q <= RED;
        RED: if (last_j) begin
          j_q <= '0;
          if (i_q == LAST) begin
            state_q <= SUB;
          end else begin
            i_q     <= i_q + ADDR_W'(1);
            state_q <= MUL;
          end
        end else begin
          j_q <= j_q + (ADDR_W + 1)'(1);
        end
        SUB: if (j_q == JSEL) state_q <= OUT;
             else j_q <= j_q + (ADDR_W + 1)'(1);
        OUT: if (!valid_q) begin
          valid_q  <= 1'b1;
          result_q <= sel_word;
          oidx_q   <= nidx;
        end else if (mm_ready) begin
          if (oidx_q == LAST) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            oidx_q   <= nidx;
            result_q <= sel_word;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mm_result = result_q;
  assign mm_valid  = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mm_cios_stream.sv
// Directed bench for mm_cios_stream at K=8, N=2, M=0xFFF1, m'=0xEF (R^-1 mod M = 0xEEE1).
module tb_mm_cios_stream;

  logic       clk = 1'b0;
  logic       rst_n, mm_start, sq_mode, in_valid, mm_ready, mm_valid, busy;
  logic [7:0] m_prime, mm_x, mm_y, mm_m, mm_result;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  mm_cios_stream #(.K(8), .N(2)) dut (
    .clk(clk), .rst_n(rst_n), .mm_start(mm_start), .sq_mode(sq_mode),
    .m_prime(m_prime), .in_valid(in_valid), .mm_x(mm_x), .mm_y(mm_y), .mm_m(mm_m),
    .mm_result(mm_result), .mm_valid(mm_valid), .mm_ready(mm_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: X*Y*R^-1 mod M with R^-1 = 0xEEE1 (15*0xEEE1 = 14*M + 1)
  function automatic logic [15:0] mont_ref(input logic [15:0] x, input logic [15:0] y);
    longint p;
    p = (longint'(x) * longint'(y)) % 64'd65521;
    return 16'((p * 64'd61153) % 64'd65521);
  endfunction

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input bit sq, input bit gap, input bit inject, input int hold,
                        input logic [15:0] exp);
    int         lat;
    logic [7:0] w0, w1;
    mm_ready = (hold == 0);
    mm_start = 1'b1;
    sq_mode  = sq;
    m_prime  = 8'hEF;
    tick();
    mm_start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    in_valid = 1'b1; mm_x = x[7:0]; mm_y = y[7:0]; mm_m = 8'hF1;
    tick();
    if (gap) begin
      in_valid = 1'b0; mm_x = 8'h55; mm_y = 8'h66;
      tick();
      tick();
    end
    in_valid = 1'b1; mm_x = x[15:8]; mm_y = y[15:8]; mm_m = 8'hFF;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!mm_valid && lat < 200) begin
      if (inject && lat == 1) begin
        mm_start = 1'b1; in_valid = 1'b1; mm_x = 8'hAA; mm_y = 8'hBB; mm_m = 8'h01;
      end else begin
        mm_start = 1'b0; in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    mm_start = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'd14);
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_hold_word0"}, 32'(mm_result), 32'(exp[7:0]));
      chk({tag, "_hold_valid"}, 32'(mm_valid), 32'd1);
      tick();
    end
    mm_ready = 1'b1;
    w0 = mm_result;
    tick();
    chk({tag, "_valid_w1"}, 32'(mm_valid), 32'd1);
    w1 = mm_result;
    tick();
    chk({tag, "_valid_fall"}, 32'(mm_valid), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, 32'({w1, w0}), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b1; mm_start = 1'b0; sq_mode = 1'b0; m_prime = 8'hEF;
    in_valid = 1'b0; mm_x = '0; mm_y = '0; mm_m = '0; mm_ready = 1'b1;
    repeat (3) tick();
    chk("reset_valid", 32'(mm_valid), 32'd0);
    chk("reset_result", 32'(mm_result), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b0;
    tick();

    run_op("r2", 16'h0001, 16'h00E1, 1'b0, 1'b0, 1'b0, 0, 16'h000F);
    run_op("final_sub", 16'hFFF0, 16'hFFF0, 1'b0, 1'b1, 1'b0, 0, 16'hEEE1);

    // Abort in RED: last op left 0xEE on mm_result, so the reset is observable
    mm_start = 1'b1; sq_mode = 1'b0;
    tick();
    mm_start = 1'b0;
    in_valid = 1'b1; mm_x = 8'hF0; mm_y = 8'hF0; mm_m = 8'hF1;
    tick();
    mm_x = 8'hFF; mm_y = 8'hFF; mm_m = 8'hFF;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    #1;
    chk("mid_reset_valid", 32'(mm_valid), 32'd0);
    chk("mid_reset_result", 32'(mm_result), 32'd0);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b0;
    tick();

    run_op("after_reset", 16'h0001, 16'h00E1, 1'b0, 1'b0, 1'b0, 0, 16'h000F);
    run_op("zero_x", 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 0, 16'h0000);
    run_op("square", 16'h000F, 16'hA5A5, 1'b1, 1'b0, 1'b0, 0, 16'h000F);
    run_op("backpressure", 16'h0001, 16'h00E1, 1'b0, 1'b0, 1'b1, 5, 16'h000F);
    run_op("mix_a", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 0, mont_ref(16'h1234, 16'h5678));
    run_op("mix_b", 16'hABCD, 16'h0102, 1'b0, 1'b1, 1'b0, 2, mont_ref(16'hABCD, 16'h0102));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
